snake_game_ctrl: RTL

Game-level sequencer for the snake datapath on a WIDTH x HEIGHT grid. It generates the step tick from a prescaler, latches the button direction and rejects reversals, and computes the next head position. It keeps a body history buffer, scans that buffer over several cycles for self-collision, and handles food/growth and the IDLE/RUN/OVER flow. The display logic reads the body through a combinational read port.

---
 rtl/snake_game_ctrl.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: step prescaler, direction latch, next-head, multi-cycle self-collision scan.
// Optional macro SNAKE_WRAP_EN: walls wrap around instead of ending the game.
module snake_game_ctrl #(
    parameter int WIDTH    = 16,
    parameter int HEIGHT   = 8,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int STEP_DIV = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic [3:0] food_x,
    input  logic [3:0] food_y,
    input  logic [3:0] rd_idx,
    output logic [3:0] rd_x,
    output logic [3:0] rd_y,
    output logic [3:0] head_x,
    output logic [3:0] head_y,
    output logic [4:0] length,
    output logic       step,
    output logic       eaten,
    output logic [1:0] state,
    output logic       game_over
);

    localparam int              PW         = $clog2(STEP_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [3:0]      X_MAX      = 4'(WIDTH - 1);
    localparam logic [3:0]      Y_MAX      = 4'(HEIGHT - 1);
    localparam logic [4:0]      LEN_INIT   = 5'(INIT_LEN);
    localparam logic [4:0]      LEN_MAX    = 5'(MAX_LEN);
    localparam logic [3:0]      DIR_RIGHT  = 4'b0001;
    localparam logic [3:0]      DIR_DOWN   = 4'b0010;
    localparam logic [3:0]      DIR_LEFT   = 4'b0100;
    localparam logic [3:0]      DIR_UP     = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    dir_q, dir_d;
    logic [3:0]    pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [3:0]    head_x_q, head_x_d, head_y_q, head_y_d;
    logic [3:0]    nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
    logic [4:0]    len_q, len_d;
    logic [3:0]    scan_q, scan_d;
    logic          step_q, step_d;
    logic          eaten_q, eaten_d;
    logic          game_over_q, game_over_d;
    logic [3:0]    body_x_q [MAX_LEN];
    logic [3:0]    body_x_d [MAX_LEN];
    logic [3:0]    body_y_q [MAX_LEN];
    logic [3:0]    body_y_d [MAX_LEN];

    logic [3:0] cand, rev_dir, eff_dir;
    logic       cand_ok;
    logic [3:0] calc_x, calc_y;
    logic       wall_hit;
    logic [3:0] scan_last;
    logic       rd_ok;

    always_comb begin
        cand = 4'd0;
        if (btnUp)         cand = DIR_UP;
        else if (btnRight) cand = DIR_RIGHT;
        else if (btnDown)  cand = DIR_DOWN;
        else if (btnLeft)  cand = DIR_LEFT;
    end

    // A reversal is the committed direction rotated by two positions.
    assign rev_dir = {dir_q[1:0], dir_q[3:2]};
    assign cand_ok = (cand != 4'd0) && (cand != rev_dir) && (cand != dir_q);
    assign eff_dir = cand_ok ? cand : (pend_vld_q ? pend_q : dir_q);

    always_comb begin
        calc_x   = head_x_q;
        calc_y   = head_y_q;
        wall_hit = 1'b0;
        if (eff_dir[0]) begin
            if (head_x_q == X_MAX) begin
`ifdef SNAKE_WRAP_EN
                calc_x = 4'd0;
`else
                wall_hit = 1'b1;
`endif
            end else calc_x = head_x_q + 4'd1;
        end else if (eff_dir[1]) begin
            if (head_y_q == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
                calc_y = 4'd0;
`else
                wall_hit = 1'b1;
`endif
            end else calc_y = head_y_q + 4'd1;
        end else if (eff_dir[2]) begin
            if (head_x_q == 4'd0) begin
`ifdef SNAKE_WRAP_EN
                calc_x = X_MAX;
`else
                wall_hit = 1'b1;
`endif
            end else calc_x = head_x_q - 4'd1;
        end else begin
            if (head_y_q == 4'd0) begin
`ifdef SNAKE_WRAP_EN
                calc_y = Y_MAX;
`else
                wall_hit = 1'b1;
`endif
            end else calc_y = head_y_q - 4'd1;
        end
    end

    // The tail entry (length-1) vacates on the move, so the scan stops at length-2.
    assign scan_last = 4'(len_q - 5'd2);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        nxt_x_d    = nxt_x_q;
        nxt_y_d    = nxt_y_q;
        len_d      = len_q;
        scan_d     = scan_q;
        body_x_d   = body_x_q;
        body_y_d   = body_y_q;
        step_d     = 1'b0;
        eaten_d    = 1'b0;
        if (cand_ok) begin
            pend_d     = cand;
            pend_vld_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                if (!pause) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d    = '0;
                        dir_d      = eff_dir;
                        pend_vld_d = 1'b0;
                        if (wall_hit) begin
                            state_d = S_OVER;
                        end else begin
                            nxt_x_d = calc_x;
                            nxt_y_d = calc_y;
                            scan_d  = 4'd0;
                            state_d = S_CHECK;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            S_CHECK: begin
                if (body_x_q[scan_q] == nxt_x_q && body_y_q[scan_q] == nxt_y_q) begin
                    state_d = S_OVER;
                end else if (scan_q == scan_last) begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        body_x_d[i] = body_x_q[i-1];
                        body_y_d[i] = body_y_q[i-1];
                    end
                    body_x_d[0] = head_x_q;
                    body_y_d[0] = head_y_q;
                    head_x_d    = nxt_x_q;
                    head_y_d    = nxt_y_q;
                    step_d      = 1'b1;
                    if (nxt_x_q == food_x && nxt_y_q == food_y) begin
                        eaten_d = 1'b1;
                        if (len_q < LEN_MAX) len_d = len_q + 5'd1;
                    end
                    state_d = S_RUN;
                end else begin
                    scan_d = scan_q + 4'd1;
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d    = S_RUN;
                    presc_d    = '0;
                    dir_d      = DIR_RIGHT;
                    pend_vld_d = 1'b0;
                    pend_d     = DIR_RIGHT;
                    head_x_d   = 4'd0;
                    head_y_d   = 4'd0;
                    nxt_x_d    = 4'd0;
                    nxt_y_d    = 4'd0;
                    len_d      = LEN_INIT;
                    scan_d     = 4'd0;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        body_x_d[i] = 4'd0;
                        body_y_d[i] = 4'd0;
                    end
                end
            end
            default: ;
        endcase
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            pend_vld_q  <= 1'b0;
            head_x_q    <= 4'd0;
            head_y_q    <= 4'd0;
            nxt_x_q     <= 4'd0;
            nxt_y_q     <= 4'd0;
            len_q       <= LEN_INIT;
            scan_q      <= 4'd0;
            step_q      <= 1'b0;
            eaten_q     <= 1'b0;
            game_over_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x_q[i] <= 4'd0;
                body_y_q[i] <= 4'd0;
            end
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            nxt_x_q     <= nxt_x_d;
            nxt_y_q     <= nxt_y_d;
            len_q       <= len_d;
            scan_q      <= scan_d;
            step_q      <= step_d;
            eaten_q     <= eaten_d;
            game_over_q <= game_over_d;
            body_x_q    <= body_x_d;
            body_y_q    <= body_y_d;
        end
    end

    assign rd_ok     = ({1'b0, rd_idx} < LEN_MAX);
    assign rd_x      = rd_ok ? body_x_q[rd_idx] : 4'd0;
    assign rd_y      = rd_ok ? body_y_q[rd_idx] : 4'd0;
    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign length    = len_q;
    assign step      = step_q;
    assign eaten     = eaten_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule
